// File: rtl/reg_readback_tx_pkg.sv
// Shared types and line levels for the register read-back serial transmitter.
package reg_readback_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  localparam int unsigned FRAME_BITS = 10;

  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;
  localparam logic IDLE_LVL  = 1'b1;

endpackage

// File: rtl/reg_readback_tx_baud_tick_gen.sv
// Bit-period timer: counts 0..CLK_DIV-1 while enabled, tick marks terminal count.
module baud_tick_gen #(
  parameter int unsigned CLK_DIV = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= (cnt == TERM) ? '0 : cnt + CW'(1);
    end
  end

  assign tick = enable && (cnt == TERM);

endmodule

// File: rtl/reg_readback_tx.sv
// Snapshots one register of the bank on request and sends it as a UART frame
// (start, 8 data bits LSB-first, stop) at CLK_DIV clocks per bit.
module reg_readback_tx
  import reg_readback_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 16,
  parameter int unsigned NUM_REGS = 4,
  parameter int unsigned AW       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  rd_valid,
  output logic                  rd_ready,
  input  logic [AW-1:0]         rd_addr,
  input  logic [8*NUM_REGS-1:0] reg_bus,
  output logic                  tx,
  output logic                  busy,
  output logic                  tx_done
);

  state_t     state;
  logic [7:0] shift;
  logic [2:0] bit_idx;
  logic [7:0] sel_byte;
  logic       accept;
  logic       baud_en;
  logic       tick;

  assign accept  = rd_valid && rd_ready;
  assign baud_en = (state != IDLE);

  // Addresses with no backing register fall through to 0x00.
  always_comb begin
    sel_byte = '0;
    for (int unsigned n = 0; n < NUM_REGS; n++) begin
      if (32'(rd_addr) == n) sel_byte = reg_bus[8*n +: 8];
    end
  end

  baud_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_baud (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (accept),
    .enable (baud_en),
    .tick   (tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      shift    <= '0;
      bit_idx  <= '0;
      tx       <= IDLE_LVL;
      busy     <= 1'b0;
      rd_ready <= 1'b1;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            shift    <= sel_byte;
            state    <= START;
            tx       <= START_LVL;
            busy     <= 1'b1;
            rd_ready <= 1'b0;
          end
        end
        START: begin
          if (tick) begin
            state   <= DATA;
            bit_idx <= '0;
            tx      <= shift[0];
          end
        end
        DATA: begin
          if (tick) begin
            // tx takes the bit that becomes shift[0] after this shift.
            shift   <= {1'b0, shift[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              tx    <= STOP_LVL;
            end else begin
              tx <= shift[1];
            end
          end
        end
        STOP: begin
          if (tick) begin
            state    <= IDLE;
            tx       <= IDLE_LVL;
            busy     <= 1'b0;
            rd_ready <= 1'b1;
            tx_done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_readback_tx.sv
// Self-checking bench: three instances (4/4, 4/3 regs, div 2) against a frame-level model.
module tb_reg_readback_tx;
  import reg_readback_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       v     [3];
  logic [1:0] a     [3];
  logic [7:0] regs  [3][4];
  logic       tx    [3];
  logic       busy  [3];
  logic       ready [3];
  logic       done  [3];
  logic [3:0] st    [3];
  logic [31:0] bus0, bus2;
  logic [23:0] bus1;

  int checks = 0;
  int errors = 0;
  int div_of  [3] = '{4, 4, 2};
  int nregs_of[3] = '{4, 3, 4};

  always #5 clk = ~clk;

  assign bus0 = {regs[0][3], regs[0][2], regs[0][1], regs[0][0]};
  assign bus1 = {regs[1][2], regs[1][1], regs[1][0]};
  assign bus2 = {regs[2][3], regs[2][2], regs[2][1], regs[2][0]};

  always_comb begin
    for (int i = 0; i < 3; i++) st[i] = {tx[i], busy[i], ready[i], done[i]};
  end

  reg_readback_tx #(.CLK_DIV(4), .NUM_REGS(4)) dut (
    .clk(clk), .reset_n(reset_n), .rd_valid(v[0]), .rd_ready(ready[0]),
    .rd_addr(a[0]), .reg_bus(bus0), .tx(tx[0]), .busy(busy[0]), .tx_done(done[0]));

  reg_readback_tx #(.CLK_DIV(4), .NUM_REGS(3)) dut_oor (
    .clk(clk), .reset_n(reset_n), .rd_valid(v[1]), .rd_ready(ready[1]),
    .rd_addr(a[1]), .reg_bus(bus1), .tx(tx[1]), .busy(busy[1]), .tx_done(done[1]));

  reg_readback_tx #(.CLK_DIV(2), .NUM_REGS(4)) dut_fast (
    .clk(clk), .reset_n(reset_n), .rd_valid(v[2]), .rd_ready(ready[2]),
    .rd_addr(a[2]), .reg_bus(bus2), .tx(tx[2]), .busy(busy[2]), .tx_done(done[2]));

  // Frame model: level index t/div walks start, b[0..7], stop; done lands at 10*div.
  function automatic logic [3:0] ref_status(logic [7:0] b, int t, int div);
    int   idx;
    logic lvl;
    idx = t / div;
    if (t >= int'(FRAME_BITS) * div) return 4'b1011;
    if (idx == 0)      lvl = 1'b0;
    else if (idx <= 8) lvl = b[idx-1];
    else               lvl = 1'b1;
    return {lvl, 3'b100};
  endfunction

  function automatic logic [7:0] ref_byte(int d, int addr);
    return (addr < nregs_of[d]) ? regs[d][addr] : 8'h00;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the request already driven; the next posedge accepts.
  task automatic run_frame(input int d, input logic [7:0] eb, input bit hold, input int last_t);
    int div;
    div = div_of[d];
    @(posedge clk);
    for (int t = 0; t <= last_t; t++) begin
      @(negedge clk);
      chk($sformatf("frame d%0d t%0d", d, t), {4'h0, st[d]}, {4'h0, ref_status(eb, t, div)});
      if (t == 0 && !hold) v[d] = 1'b0;
    end
    if (last_t == int'(FRAME_BITS) * div && !hold) begin
      @(negedge clk);
      chk($sformatf("post_idle d%0d", d), {4'h0, st[d]}, 8'h0A);
    end
  endtask

  task automatic request(input int d, input int addr);
    a[d] = 2'(addr);
    v[d] = 1'b1;
  endtask

  initial begin
    logic [7:0] eb;
    int d, addr, when;
    for (int i = 0; i < 3; i++) begin
      v[i] = 1'b0;
      a[i] = '0;
      for (int j = 0; j < 4; j++) regs[i][j] = 8'h00;
    end

    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) chk($sformatf("reset d%0d", i), {4'h0, st[i]}, 8'h0A);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_hold", {4'h0, st[0]}, 8'h0A);

    // Basic frame 0xA5 from reg 2.
    regs[0][2] = 8'hA5;
    request(0, 2);
    run_frame(0, 8'hA5, 1'b0, 40);

    // Snapshot: reg changes mid-frame must not leak into the frame.
    regs[0][0] = 8'h3C;
    request(0, 0);
    fork
      run_frame(0, 8'h3C, 1'b0, 40);
      begin
        repeat (10) @(negedge clk);
        regs[0][0] = 8'hFF;
      end
    join

    // Back-to-back with rd_valid held; address change while busy is ignored.
    regs[0][1] = 8'h01;
    regs[0][3] = 8'h80;
    request(0, 1);
    fork
      run_frame(0, 8'h01, 1'b1, 40);
      begin
        @(negedge clk);
        a[0] = 2'd3;
      end
    join
    run_frame(0, 8'h80, 1'b0, 40);

    // Out-of-range address on the 3-register instance.
    regs[1][0] = 8'hFF; regs[1][1] = 8'hFF; regs[1][2] = 8'hFF;
    request(1, 3);
    run_frame(1, ref_byte(1, 3), 1'b0, 40);

    // Divide-by-2 corner with 0xFF.
    regs[2][1] = 8'hFF;
    request(2, 1);
    run_frame(2, 8'hFF, 1'b0, 20);

    // Reset during data bit 4, then a clean frame afterwards.
    regs[0][2] = 8'hC3;
    request(0, 2);
    run_frame(0, 8'hC3, 1'b0, 21);
    reset_n = 1'b0;
    #1;
    chk("reset_async", {4'h0, st[0]}, 8'h0A);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("reset_hold %0d", i), {4'h0, st[0]}, 8'h0A);
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("after_reset_idle", {4'h0, st[0]}, 8'h0A);
    regs[0][1] = 8'h5A;
    request(0, 1);
    run_frame(0, 8'h5A, 1'b0, 40);

    // Randomized frames with mid-frame register scrambling.
    for (int it = 0; it < 9; it++) begin
      d = it % 3;
      for (int j = 0; j < 4; j++) regs[d][j] = 8'($urandom);
      addr = int'($urandom_range(0, 3));
      eb = ref_byte(d, addr);
      when = int'($urandom_range(1, 10 * div_of[d] - 2));
      request(d, addr);
      fork
        run_frame(d, eb, 1'b0, int'(FRAME_BITS) * div_of[d]);
        begin
          repeat (when) @(negedge clk);
          for (int j = 0; j < 4; j++) regs[d][j] = 8'($urandom);
        end
      join
      repeat (int'($urandom_range(0, 3))) @(negedge clk);
      chk($sformatf("rand_gap %0d", it), {4'h0, st[d]}, 8'h0A);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_readback_tx.md
# reg_readback_tx

Serial read-back transmitter for the 8-bit register bank. Accepts a read request for one register over a valid/ready handshake and snapshots that register's value. It then shifts the value out on a single UART-style line: start bit, 8 data bits LSB-first, stop bit, at a fixed clocks-per-bit rate. It sits on the output side of the register bank, as the read counterpart of the serial write path that loads the registers.

## Interface
Parameters:
- CLK_DIV, 16, clk cycles per serial bit; legal range ≥ 2.
- NUM_REGS, 4, number of 8-bit registers on reg_bus; legal range 1..16.
- AW, $clog2(NUM_REGS) (minimum 1), width of rd_addr.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- rd_valid  in  1  read request valid.
- rd_ready  out  1  block can accept a request; high only in IDLE.
- rd_addr  in  AW  register index; sampled on accept.
- reg_bus  in  8*NUM_REGS  flattened register values; register n occupies bits [8n+7:8n].
- tx  out  1  serial line; idles high.
- busy  out  1  frame in progress (any state other than IDLE).
- tx_done  out  1  one-cycle pulse when a frame completes.

## Operation
- Reset values: tx=1, busy=0, tx_done=0, rd_ready=1, state=IDLE, shift register=0x00, counters=0.
- Accept: on a rising edge where rd_valid && rd_ready, the shift register loads reg_bus[8*rd_addr +: 8].
  - If rd_addr ≥ NUM_REGS, it loads 0x00 and the frame is still sent.
- Snapshot: reg_bus changes after the accept edge do not affect the frame in flight.
- FSM states: IDLE → START → DATA → STOP → IDLE.
  - IDLE: tx=1. On accept, go to START and clear the baud counter.
  - START: tx=0 for CLK_DIV cycles, then go to DATA with bit index 0.
  - DATA: tx = shift[0] for CLK_DIV cycles, then shift right and increment the bit index. After bit 7, go to STOP.
  - STOP: tx=1 for CLK_DIV cycles, then go to IDLE and assert tx_done for that one cycle.
- Baud counter: counts 0..CLK_DIV-1, width $clog2(CLK_DIV). The bit boundary is at terminal count. The counter is forced to 0 on accept.
- Bit index: 3-bit counter. Wrap from 7 to 0 coincides with the DATA→STOP transition.
- rd_ready is decoded from registered state (IDLE), not from rd_valid.
- rd_valid outside IDLE is ignored; no request is queued.
- tx is driven from a flop (glitch-free).

## Timing
- Accept at edge k. After edge k: tx=0, busy=1, rd_ready=0.
- Data bit i is on tx from edge k+(1+i)·CLK_DIV.
- Stop bit is on tx from edge k+9·CLK_DIV.
- At edge k+10·CLK_DIV: state=IDLE, tx=1, busy=0, rd_ready=1, tx_done=1 for exactly one cycle.
- Frame length is exactly 10·CLK_DIV cycles.
- Back-to-back: with rd_valid held high, the next accept is at edge k+10·CLK_DIV+1. This leaves a one-cycle idle-high gap between frames.
- Reset asserted mid-frame: outputs return to reset values immediately (asynchronous). No tx_done pulse, and the frame is not resumed after reset.
- rd_valid and reset_n release in the same cycle: no accept on that edge; the first accept is possible on the following edge.

## Structure
- Package reg_readback_pkg holds:
  - State enum: IDLE, START, DATA, STOP.
  - FRAME_BITS = 10.
  - START_LVL = 1'b0, STOP_LVL = 1'b1, IDLE_LVL = 1'b1.
- Sub-module baud_tick_gen (parameter CLK_DIV):
  - Inputs: clk, reset_n, clear, enable.
  - Output: tick, high on terminal count.
  - Reusable by other serial blocks.
- Top level holds the FSM, the shift register, the bit index and the register-select mux.

## Test plan
All scenarios use CLK_DIV=4, NUM_REGS=4 unless noted.
- Basic frame: reg 2=0xA5, rd_addr=2, one-cycle rd_valid → tx holds, 4 cycles per level, 0,1,0,1,0,0,1,0,1,1. tx_done pulses once, 40 cycles after accept; rd_ready low throughout the frame.
- Snapshot: reg 0=0x3C, accept, then change reg 0 to 0xFF at cycle 10 → transmitted data is still 0x3C (LSB-first 0,0,1,1,1,1,0,0).
- Back-to-back: rd_valid held high, addr 1 = 0x01 then addr 3 = 0x80 → two complete frames, the second starting exactly 1 idle cycle after the first tx_done. rd_valid is ignored while busy.
- Out-of-range: NUM_REGS=3, rd_addr=3 → frame with data 0x00 (start bit, eight 0s, stop bit), tx_done asserted.
- Reset mid-frame: assert reset_n=0 during data bit 4 → tx=1, busy=0 and rd_ready=1 immediately, with no tx_done. After release, a new request for 0x5A transmits correctly.
- CLK_DIV=2 corner: 0xFF frame lasts exactly 20 cycles; tx is low only during the 2-cycle start bit.
